jiajian_acc: RTL and testbench
==============================

JIAJIAN_ACC -- requirements
Module: jiajian_acc

Interface
REQ-001 Parameter W, default 6, operand width in bits (W >= 2).
REQ-002 Parameter SAT, default 0, 0 = results wrap modulo 2^(W+1), 1 = results saturate.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 in_valid  input  1  operand set a, b, sl is presented.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 a  input  W  operand A, unsigned.
REQ-008 b  input  W  operand B, unsigned.
REQ-009 sl  input  2  mode: 00 ADD, 01 SUB, 10 ACC, 11 LOAD.
REQ-010 out_valid  output  1  c and ovf hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 c  output  W+1  registered result.
REQ-013 ovf  output  1  registered overflow/borrow flag for the result in c.

Function
REQ-014 An operation is accepted when in_valid && in_ready are both high at a rising edge.
REQ-015 in_ready SHALL equal !out_valid || out_ready (combinational, one-entry output register).
REQ-016 Latency: a result SHALL appear on c/ovf with out_valid=1 in the cycle after acceptance.
REQ-017 While out_valid && !out_ready, c, ovf and out_valid SHALL hold unchanged.
REQ-018 Accept and drain in the same cycle: the new result replaces the old one, and out_valid stays 1.
REQ-019 Drain without accept: out_valid SHALL go to 0 on the next edge.
REQ-020 ADD: c = a + b, zero-extended to W+1 bits; ovf = 0.
REQ-021 SUB: c = (a - b) mod 2^(W+1); ovf = 1 iff a < b; with SAT=1 and a < b, c = 0.
REQ-022 ACC: internal W+1-bit register acc <= acc + a; c = new acc value; b ignored.
REQ-023 ACC overflow past 2^(W+1)-1: ovf = 1; SAT=0 wraps, SAT=1 clamps acc and c to all-ones.
REQ-024 LOAD: acc <= zero-extended a; c = zero-extended a; ovf = 0.
REQ-025 acc SHALL change only on an accepted ACC or LOAD operation, never while stalled.
REQ-026 Operands are sampled only at acceptance; input changes while in_ready = 0 have no effect.

Reset
REQ-027 With rst_n = 0 at an edge: out_valid = 0, c = 0, ovf = 0, acc = 0.
REQ-028 in_ready SHALL be 1 while in reset and in the first cycle after reset.
REQ-029 Reset mid-operation discards any held result and the accumulator; no result is emitted for an operation accepted in the same cycle as reset.

Structure
REQ-030 Shared package jiajian_pkg SHALL hold the mode encodings MODE_ADD, MODE_SUB, MODE_ACC and MODE_LOAD (2-bit constants).
REQ-031 The combinational arithmetic (add/sub/acc with wrap or saturation, ovf) SHALL live in the sub-module jiajian_core, parametrised by W and SAT.
REQ-032 jiajian_acc SHALL contain only the handshake, the output register and acc.

Verification (W=6)
REQ-033 ADD: a=4, b=10, sl=00, out_ready=1 -> next cycle c=14, ovf=0, out_valid=1.
REQ-034 SUB: a=4, b=10, sl=01 -> SAT=0: c=122, ovf=1; SAT=1: c=0, ovf=1.
REQ-035 ACC sequence LOAD 60, ACC 60, ACC 60 -> c=60, 120, then SAT=0: 52 with ovf=1 / SAT=1: 127 with ovf=1.
REQ-036 Backpressure: out_ready=0 after result 14 -> c holds 14, in_ready=0 for 3 cycles, and a new request is not accepted; out_ready=1 -> drain and accept the pending request in the same cycle.
REQ-037 Reset: rst_n=0 for one cycle while a result is held and acc=120 -> out_valid=0, c=0, and a following ACC a=5 yields c=5.

Source files
------------

// File: rtl/jiajian_pkg.sv
// Shared definitions for the jiajian add/sub/accumulate block.
// Holds the 2-bit mode encodings and a small decode helper.
package jiajian_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADD  = 2'b00;
  localparam mode_t MODE_SUB  = 2'b01;
  localparam mode_t MODE_ACC  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  // Modes whose result is also written back into the accumulator.
  function automatic logic writes_acc(input mode_t mode);
    return (mode == MODE_ACC) || (mode == MODE_LOAD);
  endfunction

endpackage

// File: rtl/jiajian_core.sv
// Combinational datapath: add, subtract, accumulate or load, with either
// modulo-2^(W+1) wrap or saturation, plus the overflow/borrow flag.
module jiajian_core
  import jiajian_pkg::*;
#(
  parameter int unsigned W   = 6,
  parameter int unsigned SAT = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  mode_t        sl,
  input  logic [W:0]   acc,
  output logic [W:0]   res,
  output logic         ovf
);

  localparam bit Sat = (SAT != 0);

  logic [W:0]   add_sum;
  logic [W:0]   sub_diff;
  logic [W+1:0] acc_sum;
  logic         borrow;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};
  assign acc_sum  = {1'b0, acc} + {2'b00, a};
  assign borrow   = (a < b);

  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (sl)
      MODE_ADD: begin
        res = add_sum;
      end
      MODE_SUB: begin
        ovf = borrow;
        res = (Sat && borrow) ? '0 : sub_diff;
      end
      MODE_ACC: begin
        ovf = acc_sum[W+1];
        res = (Sat && acc_sum[W+1]) ? '1 : acc_sum[W:0];
      end
      MODE_LOAD: begin
        res = {1'b0, a};
      end
    endcase
  end

endmodule

// File: rtl/jiajian_acc.sv
// Valid/ready wrapper around jiajian_core: one-entry output register and
// the accumulator, both updated only when an operand set is accepted.
module jiajian_acc
  import jiajian_pkg::*;
#(
  parameter int unsigned W   = 6,
  parameter int unsigned SAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   sl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   c,
  output logic         ovf
);

  logic [W:0] acc_q;
  logic [W:0] c_q;
  logic       ovf_q;
  logic       out_valid_q;
  logic [W:0] core_res;
  logic       core_ovf;
  logic       accept;

  jiajian_core #(
    .W   (W),
    .SAT (SAT)
  ) u_core (
    .a   (a),
    .b   (b),
    .sl  (sl),
    .acc (acc_q),
    .res (core_res),
    .ovf (core_ovf)
  );

  // Held reset forces ready high even if a stale result was still pending.
  assign in_ready = !rst_n || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      c_q         <= core_res;
      ovf_q       <= core_ovf;
      out_valid_q <= 1'b1;
      if (writes_acc(sl)) begin
        acc_q <= core_res;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign c         = c_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_jiajian_acc.sv
// Self-checking bench for jiajian_acc: a wrapping and a saturating instance
// share stimulus; results are predicted into a scoreboard and popped on drain.
module tb_jiajian_acc;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   sl = 2'b00;
  logic         out_ready = 1'b1;

  logic         in_ready_w, out_valid_w, ovf_w;
  logic         in_ready_s, out_valid_s, ovf_s;
  logic [W:0]   c_w, c_s;

  always #5 clk = ~clk;

  jiajian_acc #(.W(W), .SAT(0)) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .a         (a),
    .b         (b),
    .sl        (sl),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .c         (c_w),
    .ovf       (ovf_w)
  );

  jiajian_acc #(.W(W), .SAT(1)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .a         (a),
    .b         (b),
    .sl        (sl),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .c         (c_s),
    .ovf       (ovf_s)
  );

  typedef struct {
    int c_w;
    int ovf_w;
    int c_s;
    int ovf_s;
  } exp_t;

  typedef struct {
    logic [1:0] sl;
    int         a;
    int         b;
    int         c_w;
    int         ovf_w;
    int         c_s;
    int         ovf_s;
  } vec_t;

  typedef struct {
    int c;
    int ovf;
    int acc;
  } ref_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   model_ov = 1'b0;
  int   acc_w = 0;
  int   acc_s = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic on plain integers, independent of bit slicing.
  function automatic ref_t ref_op(input logic [1:0] mode, input int av, input int bv,
                                  input int acc, input bit sat);
    ref_t r;
    int   s;
    r.acc = acc;
    r.ovf = 0;
    case (mode)
      2'b00: r.c = av + bv;
      2'b01: begin
        if (av < bv) begin
          r.ovf = 1;
          r.c   = sat ? 0 : av - bv + 128;
        end else begin
          r.c = av - bv;
        end
      end
      2'b10: begin
        s = acc + av;
        if (s > 127) begin
          r.ovf = 1;
          r.c   = sat ? 127 : s - 128;
        end else begin
          r.c = s;
        end
        r.acc = r.c;
      end
      default: begin
        r.c   = av;
        r.acc = av;
      end
    endcase
    return r;
  endfunction

  // One cycle: drive at negedge, check outputs, update model/scoreboard.
  task automatic step(input logic v, input logic [1:0] mode, input int av, input int bv,
                      input logic ordy, input bit use_tab, input exp_t tab);
    exp_t e;
    ref_t rw, rs;
    bit   rdy;
    @(negedge clk);
    in_valid  = v;
    sl        = mode;
    a         = av[W-1:0];
    b         = bv[W-1:0];
    out_ready = ordy;
    #1;
    rdy = !model_ov || ordy;
    chk("in_ready_wrap", in_ready_w, rdy);
    chk("in_ready_sat", in_ready_s, rdy);
    chk("out_valid_wrap", out_valid_w, model_ov);
    chk("out_valid_sat", out_valid_s, model_ov);
    if (model_ov && sb.size() > 0) begin
      e = sb[0];
      chk("c_wrap", c_w, e.c_w);
      chk("ovf_wrap", ovf_w, e.ovf_w);
      chk("c_sat", c_s, e.c_s);
      chk("ovf_sat", ovf_s, e.ovf_s);
      if (ordy) void'(sb.pop_front());
    end
    if (v && rdy) begin
      rw = ref_op(mode, av, bv, acc_w, 1'b0);
      rs = ref_op(mode, av, bv, acc_s, 1'b1);
      acc_w = rw.acc;
      acc_s = rs.acc;
      e = '{c_w: rw.c, ovf_w: rw.ovf, c_s: rs.c, ovf_s: rs.ovf};
      if (use_tab) e = tab;
      sb.push_back(e);
    end
    model_ov = (v && rdy) || (model_ov && !ordy);
  endtask

  task automatic do_reset(input logic v, input logic ordy);
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = v;
    sl        = 2'b10;
    a         = 6'd7;
    out_ready = ordy;
    #1;
    chk("rst_in_ready_wrap", in_ready_w, 1);
    chk("rst_in_ready_sat", in_ready_s, 1);
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_w, 0);
    chk("rst_c_wrap", c_w, 0);
    chk("rst_ovf_wrap", ovf_w, 0);
    chk("rst_c_sat", c_s, 0);
    chk("rst_ovf_sat", ovf_s, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    model_ov = 1'b0;
    acc_w    = 0;
    acc_s    = 0;
  endtask

  exp_t none = '{c_w: 0, ovf_w: 0, c_s: 0, ovf_s: 0};
  vec_t vecs[13];

  initial begin
    vecs[0]  = '{2'b00,  4, 10,  14, 0,  14, 0};
    vecs[1]  = '{2'b01,  4, 10, 122, 1,   0, 1};
    vecs[2]  = '{2'b11, 60,  0,  60, 0,  60, 0};
    vecs[3]  = '{2'b10, 60,  9, 120, 0, 120, 0};
    vecs[4]  = '{2'b10, 60,  0,  52, 1, 127, 1};
    vecs[5]  = '{2'b00, 63, 63, 126, 0, 126, 0};
    vecs[6]  = '{2'b01, 10,  4,   6, 0,   6, 0};
    vecs[7]  = '{2'b01,  5,  5,   0, 0,   0, 0};
    vecs[8]  = '{2'b11,  0,  0,   0, 0,   0, 0};
    vecs[9]  = '{2'b10, 63,  0,  63, 0,  63, 0};
    vecs[10] = '{2'b10, 63,  0, 126, 0, 126, 0};
    vecs[11] = '{2'b10,  1,  0, 127, 0, 127, 0};
    vecs[12] = '{2'b10,  1,  0,   0, 1, 127, 1};

    do_reset(1'b0, 1'b1);

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].sl, vecs[i].a, vecs[i].b, 1'b1, 1'b1,
           '{c_w: vecs[i].c_w, ovf_w: vecs[i].ovf_w, c_s: vecs[i].c_s, ovf_s: vecs[i].ovf_s});
    end
    step(1'b0, 2'b00, 0, 0, 1'b1, 1'b0, none);

    // Backpressure: hold 14, stall a request with changing operands, then drain+accept.
    step(1'b1, 2'b00, 4, 10, 1'b1, 1'b0, none);
    step(1'b1, 2'b00, 1, 1, 1'b0, 1'b0, none);
    step(1'b1, 2'b00, 2, 2, 1'b0, 1'b0, none);
    step(1'b1, 2'b00, 3, 3, 1'b0, 1'b0, none);
    step(1'b1, 2'b00, 20, 5, 1'b1, 1'b1, '{c_w: 25, ovf_w: 0, c_s: 25, ovf_s: 0});
    step(1'b0, 2'b00, 0, 0, 1'b1, 1'b0, none);

    // Reset while acc=120 and a result is held; same-cycle ACC is discarded.
    step(1'b1, 2'b11, 60, 0, 1'b1, 1'b0, none);
    step(1'b1, 2'b10, 60, 0, 1'b1, 1'b0, none);
    step(1'b0, 2'b00, 0, 0, 1'b0, 1'b0, none);
    do_reset(1'b1, 1'b0);
    step(1'b1, 2'b10, 5, 0, 1'b1, 1'b1, '{c_w: 5, ovf_w: 0, c_s: 5, ovf_s: 0});
    step(1'b0, 2'b00, 0, 0, 1'b1, 1'b0, none);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
           1'($urandom_range(0, 9) < 7), 1'b0, none);
    end
    step(1'b0, 2'b00, 0, 0, 1'b1, 1'b0, none);
    step(1'b0, 2'b00, 0, 0, 1'b1, 1'b0, none);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
